// File: rtl/fact_bcd_converter.sv
// -----------------------------------------------------------------------------
// fact_bcd_converter
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
//   that sits downstream of the factorial generator. It also reports how many
//   significant decimal digits the result has, for the display formatter.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     upstream presents bin_in
//   in_ready     converter idle, able to accept (decoded from state only)
//   bin_in       unsigned binary value, sampled on the accept edge only
//   out_valid    bcd_out / digit_count hold a completed conversion
//   out_ready    downstream accepts the result
//   bcd_out      packed BCD, digit 0 (units) at bits [3:0]
//   digit_count  significant digits in bcd_out, 1..DIGITS
// -----------------------------------------------------------------------------
module fact_bcd_converter #(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 10,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [CNT_W-1:0]      digit_count
);

  localparam int unsigned BCD_W    = 4 * DIGITS;
  localparam int unsigned BITCNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          r_state;
  logic [BIN_W-1:0]    r_bin;
  logic [BCD_W-1:0]    r_acc;
  logic [BITCNT_W-1:0] r_bitcnt;
  logic                r_out_valid;
  logic [BCD_W-1:0]    r_bcd_out;
  logic [CNT_W-1:0]    r_digit_count;

  logic [BCD_W-1:0]    w_acc_adj;
  logic [BCD_W-1:0]    w_acc_next;
  logic [BIN_W-1:0]    w_bin_next;
  logic [CNT_W-1:0]    w_digit_count;
  logic                w_last_shift;

  // Add 3 to every digit >= 5 so that the following left shift carries
  // correctly into the next decimal digit.
  always_comb begin
    w_acc_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end else begin
        w_acc_adj[4*i +: 4] = r_acc[4*i +: 4];
      end
    end
  end

  // {accumulator, binary} shifted left by one as a single wide register.
  assign w_acc_next   = {w_acc_adj[BCD_W-2:0], r_bin[BIN_W-1]};
  assign w_bin_next   = {r_bin[BIN_W-2:0], 1'b0};
  assign w_last_shift = (r_bitcnt == BITCNT_W'(1));

  // Highest nonzero digit wins; an all-zero value still reports one digit.
  always_comb begin
    w_digit_count = CNT_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (w_acc_next[4*i +: 4] != 4'd0) begin
        w_digit_count = CNT_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_bin         <= '0;
      r_acc         <= '0;
      r_bitcnt      <= '0;
      r_out_valid   <= 1'b0;
      r_bcd_out     <= '0;
      r_digit_count <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bin    <= bin_in;
            r_acc    <= '0;
            r_bitcnt <= BITCNT_W'(BIN_W);
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc    <= w_acc_next;
          r_bin    <= w_bin_next;
          r_bitcnt <= r_bitcnt - BITCNT_W'(1);
          if (w_last_shift) begin
            r_state       <= DONE;
            r_bcd_out     <= w_acc_next;
            r_digit_count <= w_digit_count;
            r_out_valid   <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign bcd_out     = r_bcd_out;
  assign digit_count = r_digit_count;

endmodule
